// File: rtl/sort_pair_packer.sv
// ---------------------------------------------------------------------------
// sort_pair_packer
//
// Upstream feeder for the registered two-input sorter. Accepts a serial stream
// of WIDTH-bit words on a valid/ready handshake, pairs consecutive words and
// presents each pair on registered pair_a/pair_b outputs with its own
// valid/ready handshake. A wrapping counter reports how many pairs have been
// handed downstream since reset.
//
// Parameters
//   WIDTH  bit width of each data word (matches the sorter operand width)
//   PAD    value used for the missing second word of an odd pair; the maximum
//          value by default so the lone word always sorts to the low output
//   CNT_W  width of pair_count
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_data     stream word
//   in_valid    in_data valid
//   in_last     (only with SORT_PAIR_PACKER_FLUSH_EN) final word of a burst
//   in_ready    block can accept in_data this cycle
//   pair_a      first word of the pair (earlier in the stream)
//   pair_b      second word of the pair
//   pair_valid  pair_a/pair_b valid
//   pair_ready  downstream accepts the pair this cycle
//   pair_count  number of pairs handed off since reset (wraps)
//
// Configuration
//   SORT_PAIR_PACKER_FLUSH_EN  when defined, adds in_last; a last word that
//   would otherwise wait in the hold register is emitted immediately as
//   (word, PAD), so an odd-length burst never strands a word.
// ---------------------------------------------------------------------------
module sort_pair_packer #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] PAD   = {WIDTH{1'b1}},
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
`ifdef SORT_PAIR_PACKER_FLUSH_EN
    input  logic             in_last,
`endif
    output logic             in_ready,
    output logic [WIDTH-1:0] pair_a,
    output logic [WIDTH-1:0] pair_b,
    output logic             pair_valid,
    input  logic             pair_ready,
    output logic [CNT_W-1:0] pair_count
);

    // State is the pair {hold_valid, pair_valid}; bit 0 drives pair_valid
    // directly so the output valid is always a flop.
    typedef enum logic [1:0] {
        EMPTY     = 2'b00,
        PAIR      = 2'b01,
        HALF      = 2'b10,
        HALF_PAIR = 2'b11
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] hold_next;
    logic [WIDTH-1:0] pair_a_next;
    logic [WIDTH-1:0] pair_b_next;
    logic [CNT_W-1:0] count;
    logic             in_fire;
    logic             out_fire;
    logic             last_word;

`ifdef SORT_PAIR_PACKER_FLUSH_EN
    assign last_word = in_last;
`else
    assign last_word = 1'b0;
`endif

    assign pair_valid = state[0];
    assign pair_count = count;

    // Ready depends only on registered state and the downstream ready, never
    // on in_valid, so no combinational loop can form through the upstream.
    // While rst is high state is EMPTY, which makes in_ready read 1.
    assign in_ready = !pair_valid || pair_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = pair_valid && pair_ready;

    // Next-state and datapath load selection.
    always_comb begin
        state_next  = state;
        hold_next   = hold;
        pair_a_next = pair_a;
        pair_b_next = pair_b;

        case (state)
            EMPTY: begin
                if (in_fire) begin
                    if (last_word) begin
                        // Lone final word: emit it padded instead of holding.
                        pair_a_next = in_data;
                        pair_b_next = PAD;
                        state_next  = PAIR;
                    end else begin
                        hold_next  = in_data;
                        state_next = HALF;
                    end
                end
            end

            HALF: begin
                // in_last here simply completes a normal pair.
                if (in_fire) begin
                    pair_a_next = hold;
                    pair_b_next = in_data;
                    state_next  = PAIR;
                end
            end

            PAIR: begin
                // in_ready equals pair_ready here, so in_fire implies out_fire.
                if (out_fire) begin
                    if (in_fire) begin
                        if (last_word) begin
                            pair_a_next = in_data;
                            pair_b_next = PAD;
                            state_next  = PAIR;
                        end else begin
                            hold_next  = in_data;
                            state_next = HALF;
                        end
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end

            HALF_PAIR: begin
                // Not reachable from the transitions above; kept fully
                // defined so a disturbed state still drains correctly.
                if (out_fire) begin
                    if (in_fire) begin
                        pair_a_next = hold;
                        pair_b_next = in_data;
                        state_next  = PAIR;
                    end else begin
                        state_next = HALF;
                    end
                end
            end

            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Registered state, hold word and presented pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            hold   <= '0;
            pair_a <= '0;
            pair_b <= '0;
        end else begin
            state  <= state_next;
            hold   <= hold_next;
            pair_a <= pair_a_next;
            pair_b <= pair_b_next;
        end
    end

    // Handoff counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (out_fire) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sort_pair_packer.sv
// ---------------------------------------------------------------------------
// tb_sort_pair_packer
//
// Self-checking bench for sort_pair_packer. A queue-based model pairs
// consecutive accepted words and tracks the single pending pair and the
// handoff count; every cycle the DUT outputs are compared with it. Directed
// sequences with literal expectations pin the model, followed by a random run.
// The DUT counter is built narrow so wrap-around is reached quickly.
// ---------------------------------------------------------------------------
module tb_sort_pair_packer;

    localparam int          W     = 4;
    localparam int          CW    = 8;
    localparam logic [W-1:0] PADV = {W{1'b1}};
`ifdef SORT_PAIR_PACKER_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_data;
    logic          in_valid;
`ifdef SORT_PAIR_PACKER_FLUSH_EN
    logic          in_last;
`endif
    logic          in_ready;
    logic [W-1:0]  pair_a;
    logic [W-1:0]  pair_b;
    logic          pair_valid;
    logic          pair_ready;
    logic [CW-1:0] pair_count;

    always #5 clk = ~clk;

    sort_pair_packer #(.WIDTH(W), .PAD(PADV), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
`ifdef SORT_PAIR_PACKER_FLUSH_EN
        .in_last    (in_last),
`endif
        .in_ready   (in_ready),
        .pair_a     (pair_a),
        .pair_b     (pair_b),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .pair_count (pair_count)
    );

    // Behavioural model: an unpaired word and a queue of formed pairs.
    logic             have_half;
    logic [W-1:0]     half;
    logic [2*W-1:0]   pend[$];
    int unsigned      mcount;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_clear();
        have_half = 1'b0;
        half      = '0;
        pend.delete();
        mcount    = 0;
    endtask

    // Compare every output against the model.
    task automatic compare();
        logic [2*W-1:0] head;
        check("pair_valid", 32'(pair_valid), 32'(pend.size() > 0));
        check("in_ready", 32'(in_ready), 32'((pend.size() == 0) || pair_ready));
        check("pair_count", 32'(pair_count), mcount);
        if (pend.size() > 0) begin
            head = pend[0];
            check("pair_a", 32'(pair_a), 32'(head[2*W-1:W]));
            check("pair_b", 32'(pair_b), 32'(head[W-1:0]));
        end
    endtask

    // One clock cycle: called at a negedge, drives inputs, checks, advances
    // the model across the rising edge, and returns at the next negedge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic last);
        bit exp_rdy, in_f, out_f;
        in_valid   = v;
        in_data    = d;
        pair_ready = r;
`ifdef SORT_PAIR_PACKER_FLUSH_EN
        in_last    = last;
`endif
        #1;
        compare();
        exp_rdy = (pend.size() == 0) || r;
        in_f    = v && exp_rdy;
        out_f   = (pend.size() > 0) && r;
        @(posedge clk);
        if (out_f) begin
            void'(pend.pop_front());
            mcount = (mcount + 1) % (1 << CW);
        end
        if (in_f) begin
            if (have_half) begin
                pend.push_back({half, d});
                have_half = 1'b0;
            end else if (FLUSH && last) begin
                pend.push_back({d, PADV});
            end else begin
                half      = d;
                have_half = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse asserted away from any clock edge.
    task automatic do_reset();
        #2;
        rst        = 1'b1;
        in_valid   = 1'b0;
        pair_ready = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_pair_valid", 32'(pair_valid), 32'd0);
        check("rst_pair_a", 32'(pair_a), 32'd0);
        check("rst_pair_b", 32'(pair_b), 32'd0);
        check("rst_pair_count", 32'(pair_count), 32'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        pair_ready = 1'b0;
`ifdef SORT_PAIR_PACKER_FLUSH_EN
        in_last    = 1'b0;
`endif
        model_clear();
        @(negedge clk);
        do_reset();

        // 3,9 with downstream ready
        step(1'b1, 4'h3, 1'b1, 1'b0);
        step(1'b1, 4'h9, 1'b1, 1'b0);
        check("p39_valid", 32'(pair_valid), 32'd1);
        check("p39_a", 32'(pair_a), 32'h3);
        check("p39_b", 32'(pair_b), 32'h9);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        check("p39_count", 32'(pair_count), 32'd1);

        // back-to-back stream
        do_reset();
        step(1'b1, 4'h7, 1'b1, 1'b0);
        step(1'b1, 4'h2, 1'b1, 1'b0);
        step(1'b1, 4'h5, 1'b1, 1'b0);
        step(1'b1, 4'h5, 1'b1, 1'b0);
        check("b2b_a", 32'(pair_a), 32'h5);
        check("b2b_b", 32'(pair_b), 32'h5);
        step(1'b1, 4'h0, 1'b1, 1'b0);
        step(1'b1, 4'hF, 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        check("b2b_count", 32'(pair_count), 32'd3);

        // stall with a pending pair
        do_reset();
        step(1'b1, 4'h4, 1'b0, 1'b0);
        step(1'b1, 4'h1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'h6, 1'b0, 1'b0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_a", 32'(pair_a), 32'h4);
            check("stall_b", 32'(pair_b), 32'h1);
        end
        step(1'b1, 4'h6, 1'b1, 1'b0);
        check("release_valid", 32'(pair_valid), 32'd0);
        step(1'b1, 4'h3, 1'b1, 1'b0);
        check("release_a", 32'(pair_a), 32'h6);
        check("release_b", 32'(pair_b), 32'h3);
        step(1'b0, 4'h0, 1'b1, 1'b0);

        // reset mid-pair discards the held word
        do_reset();
        step(1'b1, 4'hA, 1'b1, 1'b0);
        do_reset();
        step(1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b1, 4'h8, 1'b1, 1'b0);
        step(1'b1, 4'hC, 1'b1, 1'b0);
        check("rstmid_a", 32'(pair_a), 32'h8);
        check("rstmid_b", 32'(pair_b), 32'hC);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        check("rstmid_count", 32'(pair_count), 32'd1);

        // counter wrap
        do_reset();
        for (int i = 0; i < 600 && mcount != ((1 << CW) - 1); i++)
            step(1'b1, W'($urandom), 1'b1, 1'b0);
        check("wrap_max", 32'(pair_count), 32'((1 << CW) - 1));
        for (int i = 0; i < 4 && mcount != 0; i++)
            step(1'b1, W'($urandom), 1'b1, 1'b0);
        check("wrap_zero", 32'(pair_count), 32'd0);

`ifdef SORT_PAIR_PACKER_FLUSH_EN
        // odd burst flushed with padding
        do_reset();
        step(1'b1, 4'h2, 1'b1, 1'b0);
        step(1'b1, 4'hB, 1'b1, 1'b0);
        check("flush_a0", 32'(pair_a), 32'h2);
        check("flush_b0", 32'(pair_b), 32'hB);
        step(1'b1, 4'h6, 1'b1, 1'b1);
        check("flush_a1", 32'(pair_a), 32'h6);
        check("flush_b1", 32'(pair_b), 32'(PADV));
        step(1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b1, 4'h1, 1'b1, 1'b0);
        check("flush_nohold", 32'(pair_valid), 32'd0);
`endif

        // randomized run
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 3) != 0), W'($urandom),
                     ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0));
            end
        end
        step(1'b0, 4'h0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
